// File: rtl/multi_port_reorder_buffer.sv
// In-order-commit reorder buffer with N writeback ports, operand bypass,
// store/halt commit types and a one-cycle flush on branch mispredict.
module multi_port_reorder_buffer #(
  parameter int ROB_WIDTH   = 4,
  parameter int ROB_SIZE    = 2**ROB_WIDTH,
  parameter int WB_PORTS    = 2,
  parameter int FULL_MARGIN = 2
) (
  input  logic                          clockIn,
  input  logic                          resetIn,
  input  logic                          allocValid,
  input  logic [1:0]                    allocType,
  input  logic                          allocReady,
  input  logic [31:0]                   allocValue,
  input  logic                          allocJump,
  input  logic [4:0]                    allocDest,
  input  logic [31:0]                   allocAddr,
  output logic [ROB_WIDTH-1:0]          allocIndex,
  output logic                          full,
  output logic                          empty,
  output logic [ROB_WIDTH:0]            count,
  input  logic [WB_PORTS-1:0]           wbValid,
  input  logic [WB_PORTS*ROB_WIDTH-1:0] wbIndex,
  input  logic [WB_PORTS*32-1:0]        wbValue,
  input  logic [ROB_WIDTH-1:0]          rs1Dep,
  input  logic [ROB_WIDTH-1:0]          rs2Dep,
  output logic                          rs1Ready,
  output logic                          rs2Ready,
  output logic [31:0]                   rs1Value,
  output logic [31:0]                   rs2Value,
  output logic [ROB_WIDTH-1:0]          robBeginId,
  output logic                          commitRegValid,
  output logic [4:0]                    commitDest,
  output logic [31:0]                   commitValue,
  output logic [ROB_WIDTH-1:0]          commitRobId,
  output logic                          storeCommit,
  output logic [ROB_WIDTH-1:0]          storeRobId,
  output logic                          clear,
  output logic [31:0]                   newPc,
  output logic                          halt
);

  localparam logic [1:0] TYPE_REG    = 2'b00;
  localparam logic [1:0] TYPE_BRANCH = 2'b01;
  localparam logic [1:0] TYPE_STORE  = 2'b10;
  localparam logic [1:0] TYPE_HALT   = 2'b11;

  localparam logic [ROB_WIDTH:0] SIZE_C     = ROB_SIZE[ROB_WIDTH:0];
  localparam logic [ROB_WIDTH:0] FULL_LIMIT = SIZE_C - FULL_MARGIN[ROB_WIDTH:0];

  logic [ROB_SIZE-1:0]  valid_q;
  logic [ROB_SIZE-1:0]  ready_q;
  logic [1:0]           type_q  [ROB_SIZE];
  logic [31:0]          value_q [ROB_SIZE];
  logic                 jump_q  [ROB_SIZE];
  logic [4:0]           dest_q  [ROB_SIZE];
  logic [31:0]          addr_q  [ROB_SIZE];

  logic [ROB_WIDTH-1:0] head;
  logic [ROB_WIDTH-1:0] tail;
  logic [ROB_WIDTH:0]   count_next;

  logic [ROB_WIDTH-1:0] wb_idx [WB_PORTS];
  logic [31:0]          wb_val [WB_PORTS];
  logic [WB_PORTS-1:0]  wb_hit;

  logic                 alloc_ok;
  logic                 do_commit;
  logic                 mispredict;
  logic                 flush;
  logic                 retire;
  logic [1:0]           head_type;

  for (genvar p = 0; p < WB_PORTS; p++) begin : g_wb
    assign wb_idx[p] = wbIndex[p*ROB_WIDTH +: ROB_WIDTH];
    assign wb_val[p] = wbValue[p*32 +: 32];
    assign wb_hit[p] = wbValid[p] && valid_q[wb_idx[p]] && !clear;
  end

  // Allocation is fire-and-forget: allocValid is taken whenever an entry is
  // physically free and no flush is in progress; full is only a hint upstream.
  assign alloc_ok   = allocValid && (count < SIZE_C) && !clear;
  assign head_type  = type_q[head];
  assign do_commit  = valid_q[head] && ready_q[head] && !clear && !halt;
  assign mispredict = (head_type == TYPE_BRANCH) && (value_q[head][0] != jump_q[head]);
  assign flush      = do_commit && mispredict;
  // A halt entry stays at the head forever, so it never retires.
  assign retire     = do_commit && !mispredict && (head_type != TYPE_HALT);
  assign count_next = count + {{ROB_WIDTH{1'b0}}, alloc_ok} - {{ROB_WIDTH{1'b0}}, retire};

  assign allocIndex = tail;
  assign robBeginId = head;
  assign full       = (count >= FULL_LIMIT);
  assign empty      = (count == '0);

  function automatic logic [32:0] operand(input logic [ROB_WIDTH-1:0] dep);
    logic        rdy;
    logic [31:0] val;
    rdy = valid_q[dep] && ready_q[dep];
    val = value_q[dep];
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wbValid[p] && (wb_idx[p] == dep)) begin
        rdy = 1'b1;
        val = wb_val[p];
      end
    end
    return {rdy, val};
  endfunction

  always_comb begin
    {rs1Ready, rs1Value} = operand(rs1Dep);
    {rs2Ready, rs2Value} = operand(rs2Dep);
  end

  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      valid_q        <= '0;
      ready_q        <= '0;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      commitRegValid <= 1'b0;
      commitDest     <= '0;
      commitValue    <= '0;
      commitRobId    <= '0;
      storeCommit    <= 1'b0;
      storeRobId     <= '0;
      clear          <= 1'b0;
      newPc          <= '0;
      halt           <= 1'b0;
    end else begin
      commitRegValid <= 1'b0;
      storeCommit    <= 1'b0;
      clear          <= 1'b0;
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_hit[p]) ready_q[wb_idx[p]] <= 1'b1;
      end
      if (do_commit) begin
        case (head_type)
          TYPE_REG: begin
            commitRegValid <= 1'b1;
            commitDest     <= dest_q[head];
            commitValue    <= value_q[head];
            commitRobId    <= head;
          end
          TYPE_STORE: begin
            storeCommit <= 1'b1;
            storeRobId  <= head;
          end
          TYPE_HALT: halt <= 1'b1;
          default: ;
        endcase
      end
      if (retire) begin
        valid_q[head] <= 1'b0;
        head          <= head + ROB_WIDTH'(1);
      end
      if (alloc_ok) begin
        valid_q[tail] <= 1'b1;
        ready_q[tail] <= allocReady;
        tail          <= tail + ROB_WIDTH'(1);
      end
      count <= count_next;
      // Mispredict discards everything, including a same-cycle allocation.
      if (flush) begin
        clear   <= 1'b1;
        newPc   <= addr_q[head];
        valid_q <= '0;
        head    <= '0;
        tail    <= '0;
        count   <= '0;
      end
    end
  end

  always_ff @(posedge clockIn) begin
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_hit[p]) value_q[wb_idx[p]] <= wb_val[p];
    end
    if (alloc_ok) begin
      type_q[tail]  <= allocType;
      value_q[tail] <= allocValue;
      jump_q[tail]  <= allocJump;
      dest_q[tail]  <= allocDest;
      addr_q[tail]  <= allocAddr;
    end
  end

endmodule

// File: tb/tb_multi_port_reorder_buffer.sv
// Randomised bench for multi_port_reorder_buffer: a queue-of-entries model
// predicts commit/store/flush events, and a negedge monitor checks them.
module tb_multi_port_reorder_buffer;

  localparam int W    = 4;
  localparam int SIZE = 16;
  localparam int WB   = 2;

  logic              clockIn, resetIn;
  logic              allocValid, allocReady, allocJump;
  logic [1:0]        allocType;
  logic [31:0]       allocValue, allocAddr;
  logic [4:0]        allocDest;
  logic [W-1:0]      allocIndex;
  logic              full, empty;
  logic [W:0]        count;
  logic [WB-1:0]     wbValid;
  logic [WB*W-1:0]   wbIndex;
  logic [WB*32-1:0]  wbValue;
  logic [W-1:0]      rs1Dep, rs2Dep;
  logic              rs1Ready, rs2Ready;
  logic [31:0]       rs1Value, rs2Value;
  logic [W-1:0]      robBeginId;
  logic              commitRegValid;
  logic [4:0]        commitDest;
  logic [31:0]       commitValue;
  logic [W-1:0]      commitRobId;
  logic              storeCommit;
  logic [W-1:0]      storeRobId;
  logic              clear;
  logic [31:0]       newPc;
  logic              halt;

  multi_port_reorder_buffer #(.ROB_WIDTH(W), .WB_PORTS(WB), .FULL_MARGIN(2)) dut (
    .clockIn(clockIn), .resetIn(resetIn),
    .allocValid(allocValid), .allocType(allocType), .allocReady(allocReady),
    .allocValue(allocValue), .allocJump(allocJump), .allocDest(allocDest),
    .allocAddr(allocAddr), .allocIndex(allocIndex),
    .full(full), .empty(empty), .count(count),
    .wbValid(wbValid), .wbIndex(wbIndex), .wbValue(wbValue),
    .rs1Dep(rs1Dep), .rs2Dep(rs2Dep), .rs1Ready(rs1Ready), .rs2Ready(rs2Ready),
    .rs1Value(rs1Value), .rs2Value(rs2Value), .robBeginId(robBeginId),
    .commitRegValid(commitRegValid), .commitDest(commitDest),
    .commitValue(commitValue), .commitRobId(commitRobId),
    .storeCommit(storeCommit), .storeRobId(storeRobId),
    .clear(clear), .newPc(newPc), .halt(halt)
  );

  // clock / reset
  initial clockIn = 1'b0;
  always #5 clockIn = ~clockIn;

  typedef struct {
    int          id;
    logic [1:0]  typ;
    logic        rdy;
    logic [31:0] val;
    logic        jmp;
    logic [4:0]  dst;
    logic [31:0] adr;
  } ent_t;

  ent_t        rob_q[$];
  logic [42:0] exp_q[$];
  int          next_id;
  bit          halted_m, clear_m;
  int          checks, errors;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: {kind, id, dest, value}; kind 0 reg, 1 store, 2 flush
  task automatic mon_pop(input string name, input logic [42:0] act);
    if (exp_q.size() == 0) begin
      check({name, "_unexpected"}, 64'(act), 64'hDEAD);
    end else begin
      check(name, 64'(act), 64'(exp_q.pop_front()));
    end
  endtask

  always @(negedge clockIn) begin
    if (!resetIn) begin
      if (commitRegValid) mon_pop("commit_reg", {2'd0, commitRobId, commitDest, commitValue});
      if (storeCommit)    mon_pop("commit_store", {2'd1, storeRobId, 5'd0, 32'd0});
      if (clear)          mon_pop("flush", {2'd2, 4'd0, 5'd0, newPc});
    end
  end

  function automatic logic [32:0] model_query(input logic [W-1:0] dep);
    logic        r = 1'b0;
    logic [31:0] v = '0;
    foreach (rob_q[i]) if (rob_q[i].id == int'(dep)) begin r = rob_q[i].rdy; v = rob_q[i].val; end
    for (int p = 0; p < WB; p++)
      if (wbValid[p] && wbIndex[p*W +: W] == dep) begin r = 1'b1; v = wbValue[p*32 +: 32]; end
    return {r, v};
  endfunction

  // driver tasks
  task automatic set_alloc(input logic [1:0] t, input logic r, input logic [31:0] v,
                           input logic j, input logic [4:0] d, input logic [31:0] a);
    allocValid = 1'b1; allocType = t; allocReady = r; allocValue = v;
    allocJump = j; allocDest = d; allocAddr = a;
  endtask

  task automatic set_wb(input int p, input logic [W-1:0] idx, input logic [31:0] v);
    wbValid[p] = 1'b1;
    wbIndex[p*W +: W] = idx;
    wbValue[p*32 +: 32] = v;
  endtask

  // Check the visible state, advance the model by one clock, then clock the DUT.
  task automatic step();
    ent_t        h, e;
    bit          have_h, fl, alloc_go;
    int          pre;
    logic [32:0] q;
    #1;
    pre = rob_q.size();
    check("count", 64'(count), 64'(pre));
    check("empty", 64'(empty), 64'(pre == 0));
    check("full", 64'(full), 64'(pre >= SIZE - 2));
    check("alloc_index", 64'(allocIndex), 64'(next_id));
    check("head", 64'(robBeginId), 64'(pre > 0 ? rob_q[0].id : next_id));
    check("halt", 64'(halt), 64'(halted_m));
    check("clear", 64'(clear), 64'(clear_m));
    check("pending_events", 64'(exp_q.size()), 64'd0);
    q = model_query(rs1Dep);
    check("rs1_ready", 64'(rs1Ready), 64'(q[32]));
    if (q[32]) check("rs1_value", 64'(rs1Value), 64'(q[31:0]));
    q = model_query(rs2Dep);
    check("rs2_ready", 64'(rs2Ready), 64'(q[32]));
    if (q[32]) check("rs2_value", 64'(rs2Value), 64'(q[31:0]));

    have_h = !clear_m && !halted_m && pre > 0 && rob_q[0].rdy;
    if (pre > 0) h = rob_q[0];
    alloc_go = allocValid && pre < SIZE && !clear_m;
    fl = 1'b0;
    if (!clear_m) begin
      for (int p = 0; p < WB; p++) begin
        if (wbValid[p]) begin
          foreach (rob_q[i]) begin
            if (rob_q[i].id == int'(wbIndex[p*W +: W])) begin
              e = rob_q[i]; e.rdy = 1'b1; e.val = wbValue[p*32 +: 32]; rob_q[i] = e;
            end
          end
        end
      end
    end
    if (have_h) begin
      case (h.typ)
        2'd0: begin exp_q.push_back({2'd0, 4'(h.id), h.dst, h.val}); void'(rob_q.pop_front()); end
        2'd1: if (h.val[0] == h.jmp) void'(rob_q.pop_front()); else fl = 1'b1;
        2'd2: begin exp_q.push_back({2'd1, 4'(h.id), 5'd0, 32'd0}); void'(rob_q.pop_front()); end
        default: halted_m = 1'b1;
      endcase
    end
    if (alloc_go) begin
      e.id = next_id; e.typ = allocType; e.rdy = allocReady; e.val = allocValue;
      e.jmp = allocJump; e.dst = allocDest; e.adr = allocAddr;
      rob_q.push_back(e);
      next_id = (next_id + 1) % SIZE;
    end
    clear_m = fl;
    if (fl) begin
      rob_q.delete();
      next_id = 0;
      exp_q.push_back({2'd2, 4'd0, 5'd0, h.adr});
    end
    @(negedge clockIn);
    #1;
    allocValid = 1'b0;
    wbValid    = '0;
  endtask

  task automatic do_reset();
    resetIn = 1'b1;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_clear", 64'(clear), 64'd0);
    check("rst_halt", 64'(halt), 64'd0);
    check("rst_commit", 64'(commitRegValid), 64'd0);
    check("rst_store", 64'(storeCommit), 64'd0);
    rob_q.delete();
    exp_q.delete();
    next_id = 0; halted_m = 1'b0; clear_m = 1'b0;
    @(negedge clockIn);
    #1;
    resetIn = 1'b0;
  endtask

  initial begin
    int ids[$];
    int halt_age;
    checks = 0; errors = 0;
    allocValid = 0; allocType = 0; allocReady = 0; allocValue = 0; allocJump = 0;
    allocDest = 0; allocAddr = 0; wbValid = 0; wbIndex = 0; wbValue = 0;
    rs1Dep = 0; rs2Dep = 0;
    do_reset();

    // writeback bypass then register commit
    set_alloc(2'd0, 1'b0, 32'h0, 1'b0, 5'd5, 32'h0); step();
    set_wb(1, 4'd0, 32'h1234); rs1Dep = 4'd0;
    #1;
    check("bypass_ready", 64'(rs1Ready), 64'd1);
    check("bypass_value", 64'(rs1Value), 64'h1234);
    step();
    repeat (3) step();

    // reset with five entries live
    repeat (5) begin set_alloc(2'd0, 1'b0, $urandom, 1'b0, 5'($urandom_range(1, 31)), 32'h0); step(); end
    check("live_count", 64'(count), 64'd5);
    do_reset();

    // mispredicted branch at index 2 with younger entries behind it
    repeat (2) begin set_alloc(2'd0, 1'b1, $urandom, 1'b0, 5'd7, 32'h0); step(); end
    set_alloc(2'd1, 1'b0, 32'h0, 1'b1, 5'd0, 32'h100); step();
    repeat (3) begin set_alloc(2'd0, 1'b0, $urandom, 1'b0, 5'd9, 32'h0); step(); end
    set_wb(0, 4'd2, 32'h0); step();
    repeat (3) step();
    check("post_flush_index", 64'(allocIndex), 64'd0);
    set_alloc(2'd0, 1'b1, 32'h55, 1'b0, 5'd3, 32'h0); step();
    repeat (2) step();

    // fill to capacity, overflow attempt, drain with wrap
    repeat (14) begin set_alloc(2'd0, 1'b0, $urandom, 1'b0, 5'($urandom), 32'h0); step(); end
    check("full_at_14", 64'(full), 64'd1);
    repeat (2) begin set_alloc(2'd2, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0); step(); end
    set_alloc(2'd0, 1'b1, 32'h77, 1'b0, 5'd1, 32'h0); step();
    check("overflow_dropped", 64'(count), 64'd16);
    ids.delete();
    foreach (rob_q[i]) ids.push_back(rob_q[i].id);
    while (ids.size() > 0) begin
      set_wb(0, 4'(ids.pop_front()), $urandom);
      if (ids.size() > 0) set_wb(1, 4'(ids.pop_front()), $urandom);
      step();
    end
    repeat (20) step();
    check("drained_empty", 64'(empty), 64'd1);

    // same-index writeback on both ports, then stores commit
    do_reset();
    repeat (4) begin set_alloc(2'd2, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0); step(); end
    set_wb(0, 4'd3, 32'hA); set_wb(1, 4'd3, 32'hB); rs1Dep = 4'd3; step();
    rs2Dep = 4'd3;
    #1;
    check("dual_wb_ready", 64'(rs2Ready), 64'd1);
    check("dual_wb_value", 64'(rs2Value), 64'hB);
    step();
    set_wb(0, 4'd0, 32'h1); set_wb(1, 4'd1, 32'h2); step();
    set_wb(0, 4'd2, 32'h3); step();
    repeat (8) step();

    // halt blocks everything behind it
    do_reset();
    set_alloc(2'd3, 1'b1, 32'h0, 1'b0, 5'd0, 32'h0); step();
    set_alloc(2'd0, 1'b1, 32'h99, 1'b0, 5'd4, 32'h0); step();
    repeat (6) step();
    check("halt_sticky", 64'(halt), 64'd1);
    check("halt_count", 64'(count), 64'd2);
    do_reset();

    // random traffic
    halt_age = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int r;
      if ((cyc % 400) == 399 || halt_age > 10) begin
        do_reset();
        halt_age = 0;
      end
      if ($urandom_range(0, 3) != 0 && (!full || $urandom_range(0, 3) == 0)) begin
        r = $urandom_range(0, 99);
        set_alloc(r < 60 ? 2'd0 : r < 80 ? 2'd2 : r < 98 ? 2'd1 : 2'd3,
                  $urandom_range(0, 2) == 0, $urandom, 1'($urandom),
                  5'($urandom), $urandom);
      end
      for (int p = 0; p < WB; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          if (rob_q.size() > 0 && $urandom_range(0, 3) != 0)
            set_wb(p, 4'(rob_q[$urandom_range(0, rob_q.size() - 1)].id), $urandom);
          else
            set_wb(p, 4'($urandom), $urandom);
        end
      end
      rs1Dep = 4'($urandom);
      rs2Dep = (rob_q.size() > 0) ? 4'(rob_q[$urandom_range(0, rob_q.size() - 1)].id) : 4'($urandom);
      if (halted_m) halt_age++;
      step();
    end

    repeat (3) step();
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
